down_timer: RTL and testbench
=============================

# down_timer

Programmable down-counting timer: the decrementing companion to the 4-bit up counter. It accepts a start value over a valid/ready load handshake, counts down to zero at a prescaled rate once started, and emits a one-cycle `done` pulse on expiry. It sits beside the up counter in the timing subsystem and provides timeouts and interval events to control logic.

## Interface
- `WIDTH`, 4: width of the count and load value.
- `PRESCALE`, 1: clock cycles per decrement; legal range 1..256.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `load_valid` input 1: load request.
- `load_value` input WIDTH: start value for the countdown.
- `load_ready` output 1: load accepted when high together with `load_valid`.
- `start` input 1: begin countdown; single-cycle level, sampled.
- `pause` input 1: freeze count and prescaler while high.
- `abort` input 1: stop countdown without `done`.
- `count` output WIDTH: current remaining count.
- `busy` output 1: high in RUN.
- `done` output 1: one-cycle expiry pulse.

## Operation
- States:
  - IDLE: no value loaded.
  - ARMED: value loaded, not running.
  - RUN: counting down.
- Reset values: state IDLE, `count`=0, reload register=0, prescaler=0, `busy`=0, `done`=0, `load_ready`=1.
- `load_ready` is 1 in IDLE and ARMED, and 0 in RUN.
- Load:
  - On `load_valid && load_ready`: `count` and the reload register take `load_value`; state goes to ARMED.
  - A load while ARMED overwrites the previous value.
- Start:
  - `start` is honoured only in ARMED and ignored in IDLE and RUN.
  - If `count`=0: `done` pulses next cycle; state goes to IDLE.
  - If `count`≠0: state goes to RUN; prescaler clears to 0.
- RUN:
  - With `pause`=0, the prescaler increments each cycle.
  - When the prescaler equals PRESCALE-1, it wraps to 0 and `count` decrements.
  - With `pause`=1, the prescaler and `count` hold.
- Expiry:
  - The decrement from 1 to 0 sets `done`=1 in the same edge.
  - State goes to IDLE, or is handled as in Configuration.
- `count` never wraps below 0.
- Abort:
  - `abort` in RUN gives state IDLE, `count` holds its current value, and `done` stays 0.
  - `abort` in IDLE or ARMED moves to IDLE with `count` unchanged.
- Simultaneous events:
  - Abort coinciding with the expiry decrement: abort wins; `count` holds 1, no `done`.
  - `pause` coinciding with a prescaler tick: pause wins.
  - `start` together with a load in ARMED: the load is applied and `start` is ignored that cycle.
- Reset mid-operation returns all outputs to their reset values immediately (asynchronous), and any `done` in flight is cancelled.

## Timing
- All outputs are registered; there are no combinational input-to-output paths except `load_ready`, which decodes state only.
- Load → ARMED: 1 cycle.
- Start sampled at edge E, with `count`=N, PRESCALE=P and no pause: decrements occur at edges E+P, E+2P, … E+N·P.
- `done` is high for exactly the cycle following edge E+N·P, so latency from start to `done` is N·P cycles.
- Each paused cycle extends that latency by 1.
- `busy` rises at edge E and falls at edge E+N·P, coincident with `done`.
- A new load is accepted the cycle after `done` (state IDLE, `load_ready`=1).

## Configuration
- Macro: `DOWN_TIMER_AUTO_RELOAD_EN`.
- Defined: on expiry, `count` reloads from the reload register, state stays RUN, `busy` stays 1, and `done` still pulses; the prescaler continues counting from 0. If the reload value is 0, the timer drops to IDLE.
- Undefined: expiry always returns to IDLE with `count`=0, and the reload register is not instantiated (loads write `count` only).

## Structure
- Package `timer_pkg`:
  - state enum typedef `timer_state_t` (IDLE, ARMED, RUN);
  - constant `PRESCALE_MAX`=256;
  - prescaler-width function `clog2`-based.
- Sub-module `tick_gen`: prescaler with `clear`, `enable` and `tick` output. With PRESCALE=1, `tick` equals `enable`.
- Top level: FSM, count register, reload register, `done` register.

## Test plan
- Reset: assert `rst_n`=0 mid-RUN with `count`=5 → `count`=0, `busy`=0, `done`=0, `load_ready`=1 in the same cycle, before any clock edge.
- Basic countdown: WIDTH=4, P=1, load 3, start → `count` goes 3,2,1,0 on successive edges; `done` is high 3 cycles after the start edge, for 1 cycle; state returns to IDLE.
- Prescale and pause: P=4, load 2, start, `pause`=1 for 3 cycles during the first interval → `done` at 8+3=11 cycles after start.
- Zero and handshake: load 0, start → `done` after 1 cycle, `busy` never high; `load_valid` during RUN → `load_ready`=0 and `count` unaffected.
- Abort vs. expiry: load 1, P=1, start, `abort` on the expiry edge → no `done`, `count`=1, state IDLE.
- Auto-reload: with `DOWN_TIMER_AUTO_RELOAD_EN` defined, load 2, P=1 → `done` pulses every 2 cycles, `busy` stays 1 until abort.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and prescaler sizing for down_timer
package timer_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, RUN} timer_state_t;
    localparam int PRESCALE_MAX = 256;
    function automatic int presc_width(input int p);
        return (p > PRESCALE_MAX) ? $clog2(PRESCALE_MAX) : (p > 1) ? $clog2(p) : 1;
    endfunction
endpackage

// File: rtl/tick_gen.sv
// tick_gen: prescaler emitting one tick every PRESCALE enabled cycles
module tick_gen
    import timer_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int PW = presc_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
    logic [PW-1:0] cnt_q, cnt_d;
    always_comb begin
        tick  = enable && (cnt_q == LAST);
        cnt_d = (clear || tick) ? '0 : enable ? cnt_q + PW'(1) : cnt_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/down_timer.sv
// down_timer: loadable prescaled countdown timer with one-cycle done pulse.
// DOWN_TIMER_AUTO_RELOAD_EN: on expiry reload from the reload register and keep running.
module down_timer
    import timer_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_value,
    output logic             load_ready,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);
    timer_state_t     state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             done_q, done_d, busy_q, busy_d, tick;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
`endif
    tick_gen #(.PRESCALE(PRESCALE)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_q != RUN),
        .enable (state_q == RUN && !pause),
        .tick   (tick)
    );
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
        reload_d = reload_q;
`endif
        if (state_q == RUN) begin
            // abort beats the expiry decrement, so count keeps 1 and done stays low
            if (abort) state_d = IDLE;
            else if (tick) begin
                if (count_q == WIDTH'(1)) begin
                    done_d = 1'b1;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
                    count_d = reload_q;
                    state_d = (reload_q == '0) ? IDLE : RUN;
`else
                    count_d = '0;
                    state_d = IDLE;
`endif
                end else count_d = count_q - WIDTH'(1);
            end
        end else if (abort) state_d = IDLE;
        else if (load_valid) begin
            count_d = load_value;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
            reload_d = load_value;
`endif
            state_d = ARMED;
        end else if (start && state_q == ARMED) begin
            done_d  = (count_q == '0);
            state_d = (count_q == '0) ? IDLE : RUN;
        end
        busy_d = (state_d == RUN);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end
    assign load_ready = (state_q != RUN);
    assign count      = count_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: random and directed checks of down_timer (PRESCALE 1 and 4) against a behavioural model
module tb_down_timer;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       load_valid = 1'b0, start = 1'b0, pause = 1'b0, abort = 1'b0;
    logic [3:0] load_value = '0;
    logic [7:0] cnt_o;
    logic [1:0] rdy_o, busy_o, done_o;
    int         checks = 0, errors = 0, k;

    always #5 clk = ~clk;

    down_timer #(.WIDTH(4), .PRESCALE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_value(load_value),
        .load_ready(rdy_o[0]), .start(start), .pause(pause), .abort(abort),
        .count(cnt_o[3:0]), .busy(busy_o[0]), .done(done_o[0])
    );
    down_timer #(.WIDTH(4), .PRESCALE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_value(load_value),
        .load_ready(rdy_o[1]), .start(start), .pause(pause), .abort(abort),
        .count(cnt_o[7:4]), .busy(busy_o[1]), .done(done_o[1])
    );

    // model: remaining count plus cycles left until the next decrement
    typedef struct {bit run, armed, done; int cnt, left, rl;} model_t;
    model_t m [2];

    function automatic int ps(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) m[i] = '{default: 0};
    endtask

    task automatic step_model(input int i);
        model_t s = m[i];
        s.done = 1'b0;
        if (s.run) begin
            if (abort) s.run = 1'b0;
            else if (!pause) begin
                s.left = s.left - 1;
                if (s.left == 0) begin
                    s.cnt  = s.cnt - 1;
                    s.left = ps(i);
                    if (s.cnt == 0) begin
                        s.done = 1'b1;
                        if (AR && s.rl != 0) s.cnt = s.rl;
                        else s.run = 1'b0;
                    end
                end
            end
        end else if (abort) s.armed = 1'b0;
        else if (load_valid) begin
            s.cnt   = int'(load_value);
            s.rl    = int'(load_value);
            s.armed = 1'b1;
        end else if (start && s.armed) begin
            s.armed = 1'b0;
            if (s.cnt == 0) s.done = 1'b1;
            else begin
                s.run  = 1'b1;
                s.left = ps(i);
            end
        end
        m[i] = s;
    endtask

    task automatic compare();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("count_p%0d", ps(i)), int'(cnt_o[4*i +: 4]), m[i].cnt);
            check($sformatf("busy_p%0d", ps(i)), int'(busy_o[i]), int'(m[i].run));
            check($sformatf("done_p%0d", ps(i)), int'(done_o[i]), int'(m[i].done));
            check($sformatf("ready_p%0d", ps(i)), int'(rdy_o[i]), int'(!m[i].run));
        end
    endtask

    task automatic cycle(input bit lv, input int val, input bit st, input bit pa, input bit ab);
        @(negedge clk);
        load_valid = lv;
        load_value = 4'(val);
        start      = st;
        pause      = pa;
        abort      = ab;
        @(posedge clk);
        step_model(0);
        step_model(1);
        #1 compare();
    endtask

    task automatic idle();
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_abort();
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1 compare();

        // basic countdown with P=1
        cycle(1'b1, 3, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
        check("basic_e0_count", int'(cnt_o[3:0]), 3);
        check("basic_e0_busy", int'(busy_o[0]), 1);
        idle();
        check("basic_e1_count", int'(cnt_o[3:0]), 2);
        idle();
        check("basic_e2_count", int'(cnt_o[3:0]), 1);
        idle();
        check("basic_e3_count", int'(cnt_o[3:0]), AR ? 3 : 0);
        check("basic_e3_done", int'(done_o[0]), 1);
        idle();
        check("basic_e4_done", int'(done_o[0]), 0);
        check("basic_e4_busy", int'(busy_o[0]), AR ? 1 : 0);
        do_abort();

        // P=4, load 2, three paused cycles in the first interval
        cycle(1'b1, 2, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
        for (k = 1; k <= 40; k++) begin
            cycle(1'b0, 0, 1'b0, (k >= 2 && k <= 4), 1'b0);
            if (done_o[1]) break;
        end
        check("pause_latency_p4", k, 11);
        do_abort();

        // zero start value
        cycle(1'b1, 0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
        check("zero_done", int'(done_o[0]), 1);
        check("zero_busy", int'(busy_o[0]), 0);
        idle();
        check("zero_done_after", int'(done_o[0]), 0);

        // load attempt while running is refused
        cycle(1'b1, 5, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 9, 1'b0, 1'b0, 1'b0);
        check("run_load_count", int'(cnt_o[3:0]), 4);
        check("run_load_ready", int'(rdy_o[0]), 0);
        do_abort();

        // abort on the expiry edge
        cycle(1'b1, 1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
        do_abort();
        check("abort_exp_count", int'(cnt_o[3:0]), 1);
        check("abort_exp_done", int'(done_o[0]), 0);
        check("abort_exp_busy", int'(busy_o[0]), 0);
        cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
        check("abort_exp_start_ignored", int'(busy_o[0]), 0);

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
        cycle(1'b1, 2, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
        for (int j = 1; j <= 8; j++) begin
            idle();
            check("reload_done", int'(done_o[0]), int'(j % 2 == 0));
            check("reload_busy", int'(busy_o[0]), 1);
        end
        do_abort();
        check("reload_abort_busy", int'(busy_o[0]), 0);
`endif

        // asynchronous reset in the middle of a countdown
        cycle(1'b1, 5, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_count", int'(cnt_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_done", int'(done_o), 0);
        check("rst_ready", int'(rdy_o), 3);
        model_reset();
        @(negedge clk) rst_n = 1'b1;

        repeat (2000) begin
            cycle($urandom_range(0, 3) == 0,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4)),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 24) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
